// File: rtl/hs_pattern_master.sv
// Valid/ready burst source: counter, LFSR or constant data, programmable length and inter-beat gap.
// Latency: start sampled on edge N gives M_valid=1 after edge N; final handshake -> done -> IDLE (2 cycles to next beat).
// Backpressure: M_valid/M_data/M_last hold stable until M_ready; data and beat_cnt advance only on a handshake.
// Ports: clk, rst (async active-low); start/mode/seed/burst_len/gap = burst request and config (sampled in IDLE);
//        M_data/M_valid/M_last/M_ready = output stream; busy (SEND or GAP), done (1-cycle pulse), beat_cnt.
module hs_pattern_master #(
    parameter int                 DATA_W = 8,
    parameter int                 LEN_W  = 8,
    parameter int                 GAP_W  = 4,
    parameter logic [DATA_W-1:0]  TAPS   = 8'hB8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic [GAP_W-1:0]  gap,
    input  logic              M_ready,
    output logic [DATA_W-1:0] M_data,
    output logic              M_valid,
    output logic              M_last,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  beat_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state;
    logic [1:0]         mode_q;
    logic [LEN_W-1:0]   len_q;
    logic [GAP_W-1:0]   gap_q;
    logic [GAP_W-1:0]   gap_cnt;

    // Next data value for the latched mode; constant mode covers both 2 and 3.
    function automatic logic [DATA_W-1:0] next_data(input logic [1:0] m, input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        case (m)
            2'd0:    r = d + DATA_W'(1);
            2'd1:    r = {d[DATA_W-2:0], ^(d & TAPS)};
            default: r = d;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            mode_q   <= '0;
            len_q    <= '0;
            gap_q    <= '0;
            gap_cnt  <= '0;
            M_data   <= '0;
            M_valid  <= 1'b0;
            M_last   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            beat_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A zero-length request is dropped without leaving IDLE.
                    if (start && (burst_len != '0)) begin
                        state    <= S_SEND;
                        mode_q   <= mode;
                        len_q    <= burst_len;
                        gap_q    <= gap;
                        beat_cnt <= '0;
                        M_valid  <= 1'b1;
                        busy     <= 1'b1;
                        M_last   <= (burst_len == LEN_W'(1));
                        // An all-zero LFSR would lock up, so seed 0 becomes 1.
                        if ((mode == 2'd1) && (seed == '0))
                            M_data <= DATA_W'(1);
                        else
                            M_data <= seed;
                    end
                end
                S_SEND: begin
                    // M_valid is always 1 here, so M_ready alone marks a handshake.
                    if (M_ready) begin
                        beat_cnt <= beat_cnt + LEN_W'(1);
                        M_data   <= next_data(mode_q, M_data);
                        if (M_last) begin
                            state   <= S_DONE;
                            M_valid <= 1'b0;
                            M_last  <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else if (gap_q != '0) begin
                            state   <= S_GAP;
                            M_valid <= 1'b0;
                            M_last  <= 1'b0;
                            gap_cnt <= gap_q - GAP_W'(1);
                        end else begin
                            M_last  <= ((beat_cnt + LEN_W'(1)) == (len_q - LEN_W'(1)));
                        end
                    end
                end
                S_GAP: begin
                    // gap_cnt starts at gap-1 so GAP lasts exactly gap cycles.
                    if (gap_cnt == '0) begin
                        state   <= S_SEND;
                        M_valid <= 1'b1;
                        M_last  <= (beat_cnt == (len_q - LEN_W'(1)));
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hs_pattern_master.sv
// Directed bench for hs_pattern_master: counter wrap, LFSR, backpressure, gaps,
// ignored requests and mid-burst reset, against hand-computed beat sequences.
// Inputs are driven and outputs checked on the falling clock edge.
module tb_hs_pattern_master;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic [7:0] seed;
    logic [7:0] burst_len;
    logic [3:0] gap;
    logic       M_ready;
    logic [7:0] M_data;
    logic       M_valid;
    logic       M_last;
    logic       busy;
    logic       done;
    logic [7:0] beat_cnt;

    int n_cmp = 0;
    int n_err = 0;

    hs_pattern_master #(
        .DATA_W (8),
        .LEN_W  (8),
        .GAP_W  (4),
        .TAPS   (8'hB8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .seed      (seed),
        .burst_len (burst_len),
        .gap       (gap),
        .M_ready   (M_ready),
        .M_data    (M_data),
        .M_valid   (M_valid),
        .M_last    (M_last),
        .busy      (busy),
        .done      (done),
        .beat_cnt  (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after start was sampled.
    task automatic do_start(input logic [1:0] m, input logic [7:0] s,
                            input logic [7:0] l, input logic [3:0] g);
        start     = 1'b1;
        mode      = m;
        seed      = s;
        burst_len = l;
        gap       = g;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic check_beat(input string tag, input logic [7:0] d, input logic l);
        check({tag, "_valid"}, M_valid, 1'b1);
        check({tag, "_data"},  M_data,  d);
        check({tag, "_last"},  M_last,  l);
    endtask

    // Expects the done cycle now, then steps into IDLE.
    task automatic check_done(input string tag, input logic [7:0] cnt);
        check({tag, "_done"},  done,     1'b1);
        check({tag, "_valid0"}, M_valid, 1'b0);
        check({tag, "_busy0"}, busy,     1'b0);
        check({tag, "_cnt"},   beat_cnt, cnt);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 1'b0);
    endtask

    logic [7:0] lfsr_exp [5]    = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
    logic       gap_vld  [7]    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic       gap_lst  [7]    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; start = 1'b0; mode = '0; seed = '0; burst_len = '0; gap = '0; M_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", M_valid, 1'b0);
        check("rst_data",  M_data,  8'h00);
        check("rst_busy",  busy,    1'b0);
        check("rst_done",  done,    1'b0);
        check("rst_cnt",   beat_cnt, 8'h00);
        check("rst_last",  M_last,  1'b0);
        rst = 1'b1;
        @(negedge clk);

        // Counter wrap, continuous beats
        M_ready = 1'b1;
        do_start(2'd0, 8'hFE, 8'd3, 4'd0);
        check("cnt_busy", busy, 1'b1);
        check_beat("cnt0", 8'hFE, 1'b0); @(negedge clk);
        check_beat("cnt1", 8'hFF, 1'b0); @(negedge clk);
        check_beat("cnt2", 8'h00, 1'b1); @(negedge clk);
        check_done("cnt", 8'd3);

        // LFSR sequence
        do_start(2'd1, 8'h01, 8'd5, 4'd0);
        for (int i = 0; i < 5; i++) begin
            check_beat($sformatf("lfsr%0d", i), lfsr_exp[i], (i == 4));
            @(negedge clk);
        end
        check_done("lfsr", 8'd5);

        // LFSR with zero seed
        do_start(2'd1, 8'h00, 8'd1, 4'd0);
        check_beat("lfsr0seed", 8'h01, 1'b1); @(negedge clk);
        check_done("lfsr0seed", 8'd1);

        // Backpressure: ready low for 3 cycles
        M_ready = 1'b0;
        do_start(2'd0, 8'h10, 8'd2, 4'd0);
        for (int i = 0; i < 3; i++) begin
            check_beat($sformatf("bp_hold%0d", i), 8'h10, 1'b0);
            check($sformatf("bp_cnt%0d", i), beat_cnt, 8'd0);
            if (i < 2) @(negedge clk);
        end
        M_ready = 1'b1;
        @(negedge clk);
        check_beat("bp1", 8'h11, 1'b1); @(negedge clk);
        check_done("bp", 8'd2);
        // Ready high while idle changes nothing
        repeat (2) @(negedge clk);
        check("idle_ready_cnt",   beat_cnt, 8'd2);
        check("idle_ready_valid", M_valid,  1'b0);

        // Constant mode with gap=2
        do_start(2'd2, 8'hA5, 8'd3, 4'd2);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("gap_valid%0d", i), M_valid, gap_vld[i]);
            check($sformatf("gap_data%0d", i),  M_data,  8'hA5);
            check($sformatf("gap_last%0d", i),  M_last,  gap_lst[i]);
            check($sformatf("gap_busy%0d", i),  busy,    1'b1);
            @(negedge clk);
        end
        check_done("gap", 8'd3);

        // Zero-length request ignored
        do_start(2'd0, 8'h33, 8'd0, 4'd0);
        check("len0_valid", M_valid, 1'b0);
        check("len0_busy",  busy,    1'b0);
        @(negedge clk);
        check("len0_busy2", busy,    1'b0);

        // Start mid-burst ignored, latched config kept
        do_start(2'd0, 8'h20, 8'd4, 4'd0);
        check_beat("mid0", 8'h20, 1'b0);
        do_start(2'd1, 8'h77, 8'd1, 4'd3);
        check_beat("mid1", 8'h21, 1'b0); @(negedge clk);
        check_beat("mid2", 8'h22, 1'b0); @(negedge clk);
        check_beat("mid3", 8'h23, 1'b1); @(negedge clk);
        // Start during the done cycle is ignored
        check("dn_done", done, 1'b1);
        do_start(2'd0, 8'h50, 8'd2, 4'd0);
        check("dn_valid", M_valid, 1'b0);
        check("dn_busy",  busy,    1'b0);
        check("dn_cnt",   beat_cnt, 8'd4);
        @(negedge clk);
        check("dn_valid2", M_valid, 1'b0);

        // Reset mid-burst
        do_start(2'd0, 8'h40, 8'd4, 4'd0);
        check_beat("rm0", 8'h40, 1'b0); @(negedge clk);
        check_beat("rm1", 8'h41, 1'b0); @(negedge clk);
        check_beat("rm2", 8'h42, 1'b0);
        rst = 1'b0;
        #1;
        check("rm_valid", M_valid,  1'b0);
        check("rm_busy",  busy,     1'b0);
        check("rm_done",  done,     1'b0);
        check("rm_cnt",   beat_cnt, 8'd0);
        check("rm_data",  M_data,   8'h00);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rm_idle_valid", M_valid, 1'b0);
        check("rm_idle_done",  done,    1'b0);
        do_start(2'd0, 8'h00, 8'd2, 4'd0);
        check_beat("rmn0", 8'h00, 1'b0); @(negedge clk);
        check_beat("rmn1", 8'h01, 1'b1); @(negedge clk);
        check_done("rmn", 8'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
